// File: rtl/flag_pkg.sv
// Shared definitions for the flag-register controller: opcodes, condition codes,
// {N,V,Z} bit positions, FSM states and the opcode-to-flag write mask.
package flag_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  // Bit positions inside a {N,V,Z} flag vector
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] MASK_ALL  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b001;
  localparam logic [2:0] MASK_NONE = 3'b000;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_AL = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic [2:0] flag_mask(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB:                 flag_mask = MASK_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = MASK_Z;
      default:                        flag_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flag_ctrl_if.sv
// Decode/execute-side signal bundle of the flag controller.
// master = core pipeline side, slave = flag_ctrl.
interface flag_ctrl_if;
  logic       id_adv;
  logic [3:0] id_opcode;
  logic       ex_we;
  logic [3:0] ex_opcode;
  logic [2:0] ex_flags;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       flush;
  logic       N_flag;
  logic       Z_flag;
  logic       V_flag;
  logic       br_stall;
  logic       br_resolved;
  logic       br_taken;

  modport master (
    output id_adv, id_opcode, ex_we, ex_opcode, ex_flags, br_valid, br_cond, flush,
    input  N_flag, Z_flag, V_flag, br_stall, br_resolved, br_taken
  );

  modport slave (
    input  id_adv, id_opcode, ex_we, ex_opcode, ex_flags, br_valid, br_cond, flush,
    output N_flag, Z_flag, V_flag, br_stall, br_resolved, br_taken
  );
endinterface

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition evaluation on a {N,V,Z} flag vector.
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic n, v, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CC_NE:   taken = !z;
      CC_EQ:   taken = z;
      CC_GT:   taken = !z && !n;
      CC_LT:   taken = n;
      CC_GE:   taken = z || !n;
      CC_LE:   taken = n || z;
      CC_OV:   taken = v;
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Flag register, in-flight flag-writer counter and branch stall/resolve FSM.
// Optional build macro FLAG_CTRL_BYPASS_EN forwards completing ALU flags to a waiting branch.
module flag_ctrl
  import flag_pkg::*;
#(
  parameter int EX_STAGES = 1
) (
  input logic        clk,
  input logic        rst_n,
  flag_ctrl_if.slave bus
);

  // state | meaning
  // IDLE  | no branch held; a hazard-free branch resolves combinationally
  // WAIT  | branch held in decode until the pending flag writers drain

  localparam int PW = $clog2(EX_STAGES + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(EX_STAGES);

  logic [2:0]    flags_q;
  logic [PW-1:0] pending_q;
  state_e        state_q;

  logic [2:0] ex_mask, id_mask, merged, eff;
  logic       inc, dec, byp, hazard, cond_true, resolve, stall;

  assign ex_mask = flag_mask(bus.ex_opcode);
  assign id_mask = flag_mask(bus.id_opcode);
  assign inc     = bus.id_adv && !bus.flush && (id_mask != MASK_NONE);
  assign dec     = bus.ex_we && (ex_mask != MASK_NONE);
  assign merged  = (bus.ex_flags & ex_mask) | (flags_q & ~ex_mask);

`ifdef FLAG_CTRL_BYPASS_EN
  assign byp = (pending_q == PW'(1)) && dec;
`else
  assign byp = 1'b0;
`endif

  assign eff    = byp ? merged : flags_q;
  assign hazard = bus.br_valid && (pending_q != '0) && !byp && (bus.br_cond != CC_AL);

  flag_cond_eval u_cond (
    .flags (eff),
    .cond  (bus.br_cond),
    .taken (cond_true)
  );

  // A flush in WAIT squashes the held branch, so it neither stalls nor resolves
  always_comb begin
    resolve = 1'b0;
    stall   = 1'b0;
    if (!rst_n && bus.br_valid && !(state_q == ST_WAIT && bus.flush)) begin
      resolve = !hazard;
      stall   = hazard;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      flags_q   <= '0;
      pending_q <= '0;
    end else begin
      if (bus.ex_we) flags_q <= merged;
      if (inc && !dec && pending_q != PEND_MAX)
        pending_q <= pending_q + PW'(1);
      else if (dec && !inc && pending_q != '0)
        pending_q <= pending_q - PW'(1);
      assert (!(inc && !dec && pending_q == PEND_MAX))
        else $error("flag_ctrl: pending counter overflow");
      assert (!(dec && !inc && pending_q == '0))
        else $error("flag_ctrl: pending counter underflow");
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.br_valid && hazard) state_q <= ST_WAIT;
        ST_WAIT: if (bus.flush || !bus.br_valid || !hazard) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.N_flag      = flags_q[FLAG_N];
  assign bus.Z_flag      = flags_q[FLAG_Z];
  assign bus.V_flag      = flags_q[FLAG_V];
  assign bus.br_stall    = stall;
  assign bus.br_resolved = resolve;
  assign bus.br_taken    = resolve && cond_true;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: expected {N,Z,V,stall,resolved,taken} queued per driven cycle.
module tb_flag_ctrl;
  import flag_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  flag_ctrl_if bus();

  flag_ctrl #(.EX_STAGES(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Drive one cycle of inputs at the falling edge, queue the expectation, then
  // compare mid-cycle before the next rising edge commits state.
  task automatic step(input logic rst, input logic adv, input logic [3:0] idop,
                      input logic we, input logic [3:0] exop, input logic [2:0] exf,
                      input logic bv, input logic [2:0] bc, input logic fl,
                      input string tag, input logic [5:0] exp);
    exp_t       e;
    logic [5:0] obs;
    @(negedge clk);
    rst_n         = rst;
    bus.id_adv    = adv;
    bus.id_opcode = idop;
    bus.ex_we     = we;
    bus.ex_opcode = exop;
    bus.ex_flags  = exf;
    bus.br_valid  = bv;
    bus.br_cond   = bc;
    bus.flush     = fl;
    sb.push_back('{tag, exp});
    #1;
    obs = {bus.N_flag, bus.Z_flag, bus.V_flag, bus.br_stall, bus.br_resolved, bus.br_taken};
    e = sb.pop_front();
    tests++;
    assert (obs === e.exp)
      else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b (NZV,stall,res,taken)", e.tag, obs, e.exp);
      end
  endtask

  logic [7:0] sweep_taken;

  initial begin
    rst_n         = 1'b1;
    bus.id_adv    = 1'b0;
    bus.id_opcode = 4'h0;
    bus.ex_we     = 1'b0;
    bus.ex_opcode = 4'h0;
    bus.ex_flags  = 3'b000;
    bus.br_valid  = 1'b0;
    bus.br_cond   = 3'b000;
    bus.flush     = 1'b0;
    sweep_taken   = 8'hD5;

    // reset: branch outputs held low even with an unconditional branch present
    step(1, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_AL, 0, "reset",       6'b000_000);

    // ADD writes all three flags; XOR writes Z only
    step(0, 1, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "add_issue",   6'b000_000);
    step(0, 0, OP_ADD, 1, OP_ADD, 3'b101, 0, CC_NE, 0, "add_we",      6'b000_000);
    step(0, 1, OP_XOR, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "add_flags",   6'b110_000);
    step(0, 0, OP_ADD, 1, OP_XOR, 3'b010, 0, CC_NE, 0, "xor_we",      6'b110_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "xor_flags",   6'b100_000);

    // SUB in flight, EQ branch directly behind it
    step(0, 1, OP_SUB, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "sub_issue",   6'b100_000);
`ifdef FLAG_CTRL_BYPASS_EN
    step(0, 0, OP_ADD, 1, OP_SUB, 3'b001, 1, CC_EQ, 0, "br_bypass",   6'b100_011);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_EQ, 0, "br_after",    6'b010_000);
`else
    step(0, 0, OP_ADD, 1, OP_SUB, 3'b001, 1, CC_EQ, 0, "br_stall",    6'b100_100);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_EQ, 0, "br_resolve",  6'b010_011);
`endif

    // flushed flag writer never counts as pending
    step(0, 1, OP_SUB, 0, OP_ADD, 3'b000, 0, CC_NE, 1, "flush_issue", 6'b010_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_NE, 0, "flush_br",    6'b010_010);

    // unconditional branch ignores the pending writer
    step(0, 1, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "add2_issue",  6'b010_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_AL, 0, "br_always",   6'b010_011);
    step(0, 0, OP_ADD, 1, OP_ADD, 3'b110, 0, CC_NE, 0, "add2_we",     6'b010_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "add2_flags",  6'b101_000);

    // WAIT exited by flush, re-entered, then reset mid-WAIT
    step(0, 1, OP_SLL, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "sll_issue",   6'b101_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_LT, 0, "wait_enter",  6'b101_100);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_LT, 1, "wait_flush",  6'b101_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_LT, 0, "wait_again",  6'b101_100);
    step(1, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_LT, 0, "rst_assert",  6'b101_000);
    step(1, 0, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_LT, 0, "rst_clear",   6'b000_000);
    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, CC_LT, 0, "post_rst_br", 6'b000_010);

    // N=0 Z=0 V=1, then sweep all condition codes
    step(0, 1, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "add3_issue",  6'b000_000);
    step(0, 0, OP_ADD, 1, OP_ADD, 3'b010, 0, CC_NE, 0, "add3_we",     6'b000_000);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 1, 3'(i), 0, $sformatf("cond_%0d", i),
           {3'b001, 1'b0, 1'b1, sweep_taken[i]});
    end

    step(0, 0, OP_ADD, 0, OP_ADD, 3'b000, 0, CC_NE, 0, "final_idle",  6'b001_000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
